// File: rtl/clock_monitor.sv
// clock_monitor: watches a divided clock (sig_in) sampled in the clk_in domain.
// It measures the rising-edge to rising-edge period and compares it with the
// expected value. It reports lock after a run of good periods and raises a
// sticky fault on a bad period or on missing edges.
module clock_monitor #(
    parameter int EXPECTED_PERIOD = 4,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    input  logic             clear_fault,
    output logic             locked,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    // Acceptance window; the lower bound clamps at zero for wide tolerances.
    localparam int LO_INT = (EXPECTED_PERIOD > TOLERANCE) ? EXPECTED_PERIOD - TOLERANCE : 0;
    localparam logic [CNT_W-1:0] LO_BOUND  = CNT_W'(LO_INT);
    localparam logic [CNT_W-1:0] HI_BOUND  = CNT_W'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // good_cnt only has to count up to LOCK_COUNT.
    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [GC_W-1:0] LOCK_LAST = GC_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t            state;
    logic              s1;
    logic              s2;
    logic              d;
    logic [CNT_W-1:0]  cnt;
    logic [GC_W-1:0]   good_cnt;
    logic              rise;
    logic              good;
    logic              timeout;

    // Edge detect on the synchronized input, plus the period checks against cnt.
    assign rise    = s2 & ~d;
    assign good    = (cnt >= LO_BOUND) && (cnt <= HI_BOUND);
    assign timeout = (cnt >= TIMEOUT_V) && !rise;

    // Two-flop synchronizer and delayed copy. These keep running while disabled,
    // so no stale edge is pending when enable returns.
    always_ff @(posedge clk_in) begin
        // NOTE: every register assignment here is non-blocking, so each flop
        // samples the pre-edge value of its neighbour. A blocking assignment
        // would collapse the chain into a single flop.
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    // Period counter, lock/fault FSM and registered status outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            locked       <= 1'b0;
            fault_sticky <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            // NOTE: the clear comes before the FSM on purpose. A fault event
            // later in this block also assigns fault_sticky, and the last
            // non-blocking assignment wins, so a simultaneous set beats the clear.
            if (clear_fault) begin
                fault_sticky <= 1'b0;
            end

            if (!enable) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                if (rise) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end

                // The first edge after IDLE only starts a measurement.
                if (rise && state != ST_IDLE) begin
                    period       <= cnt;
                    period_valid <= 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state    <= ST_ACQUIRE;
                            good_cnt <= '0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (rise) begin
                            if (good) begin
                                good_cnt <= good_cnt + GC_W'(1);
                                if (good_cnt == LOCK_LAST) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end else if (timeout) begin
                            state        <= ST_FAULT;
                            fault_sticky <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if ((rise && !good) || timeout) begin
                            state        <= ST_FAULT;
                            locked       <= 1'b0;
                            fault_sticky <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        // A timeout here is not a new fault event.
                        if (rise) begin
                            state    <= ST_ACQUIRE;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed stimulus for clock_monitor. A timestamp-based
// reference model runs beside the DUT and is compared against it every cycle.
// Literal checks at key points pin the model.
module tb_clock_monitor;

    localparam int EXP_P = 4;
    localparam int TOL   = 0;
    localparam int LOCKN = 4;
    localparam int TMO   = 16;
    localparam int CMAX  = 65535;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable;
    logic        sig_in;
    logic        clear_fault;
    logic        locked;
    logic        fault_sticky;
    logic [15:0] period;
    logic        period_valid;

    int tests = 0;
    int fails = 0;

    clock_monitor #(
        .EXPECTED_PERIOD(EXP_P),
        .TOLERANCE(TOL),
        .LOCK_COUNT(LOCKN),
        .TIMEOUT(TMO),
        .CNT_W(16)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .enable(enable),
        .sig_in(sig_in),
        .clear_fault(clear_fault),
        .locked(locked),
        .fault_sticky(fault_sticky),
        .period(period),
        .period_valid(period_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The period is the distance in edges from the last counter restart. The
    // mode tracks which phase the monitor is in.
    typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mode_t;

    bit    samp [3];        // sig_in seen 1, 2 and 3 edges ago
    int    edge_n = 0;
    int    last_start = 0;  // edge at which the running count was "1 before"
    mode_t mode = M_IDLE;
    int    good_run = 0;
    int    m_period = 0;
    bit    m_pv = 0;
    bit    m_locked = 0;
    bit    m_fault = 0;
    bit    model_ready = 0;

    always @(posedge clk_in) begin
        int  c;
        bit  r;
        bit  ok;
        bit  tmo;
        edge_n++;
        r = samp[1] && !samp[2];
        c = edge_n - last_start;
        if (c > CMAX) c = CMAX;
        if (reset) begin
            samp       = '{0, 0, 0};
            last_start = edge_n + 1;
            mode       = M_IDLE;
            good_run   = 0;
            m_period   = 0;
            m_pv       = 0;
            m_locked   = 0;
            m_fault    = 0;
            model_ready = 1;
        end else begin
            samp[2] = samp[1];
            samp[1] = samp[0];
            samp[0] = sig_in;
            m_pv = 0;
            if (clear_fault) m_fault = 0;
            if (!enable) begin
                mode       = M_IDLE;
                good_run   = 0;
                last_start = edge_n + 1;
            end else begin
                ok  = (c >= ((EXP_P > TOL) ? EXP_P - TOL : 0)) && (c <= EXP_P + TOL);
                tmo = !r && (c >= TMO);
                if (r) last_start = edge_n;
                if (r && mode != M_IDLE) begin
                    m_period = c;
                    m_pv     = 1;
                end
                if (mode == M_IDLE) begin
                    if (r) begin mode = M_ACQ; good_run = 0; end
                end else if (mode == M_ACQ) begin
                    if (r && ok) begin
                        good_run++;
                        if (good_run == LOCKN) mode = M_LOCK;
                    end else if (r) begin
                        good_run = 0;
                    end else if (tmo) begin
                        mode = M_FAULT; m_fault = 1;
                    end
                end else if (mode == M_LOCK) begin
                    if ((r && !ok) || tmo) begin mode = M_FAULT; m_fault = 1; end
                end else begin
                    if (r) begin mode = M_ACQ; good_run = 0; end
                end
            end
            m_locked = (mode == M_LOCK);
        end
    end

    // ---------------- per-cycle compare ----------------
    int pv_count = 0;
    bit saw_p6 = 0;

    always @(negedge clk_in) begin
        if (model_ready) begin
            check("cyc_locked", 32'(locked), 32'(m_locked));
            check("cyc_fault_sticky", 32'(fault_sticky), 32'(m_fault));
            check("cyc_period_valid", 32'(period_valid), 32'(m_pv));
            check("cyc_period", 32'(period), 32'(m_period));
            if (period_valid === 1'b1) begin
                pv_count++;
                if (period == 16'd6) saw_p6 = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic pulse_train(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            tick(hi);
            sig_in = 1'b0;
            tick(lo);
        end
    endtask

    initial begin
        int base;
        reset = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        clear_fault = 1'b0;
        tick(2);
        check("rst_locked", 32'(locked), 0);
        check("rst_fault", 32'(fault_sticky), 0);
        check("rst_period", 32'(period), 0);
        check("rst_pv", 32'(period_valid), 0);
        reset = 1'b0;
        enable = 1'b1;

        // 1: nominal square wave, lock after start edge + 4 good periods
        base = pv_count;
        pulse_train(6, 2, 2);
        tick(2);
        check("t1_pv_pulses", 32'(pv_count - base), 5);
        check("t1_locked", 32'(locked), 1);
        check("t1_period", 32'(period), 4);
        check("t1_fault", 32'(fault_sticky), 0);

        // 2: missing edges -> timeout fault 16 cycles after the last restart
        base = pv_count;
        tick(10);
        check("t2_still_locked", 32'(locked), 1);
        tick(15);
        check("t2_locked", 32'(locked), 0);
        check("t2_fault", 32'(fault_sticky), 1);
        check("t2_no_pv", 32'(pv_count - base), 0);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("t2_cleared", 32'(fault_sticky), 0);
        pulse_train(6, 2, 2);
        check("t2_relocked", 32'(locked), 1);

        // 3: one stretched period of 6 -> fault, then relock with fault held
        saw_p6 = 0;
        pulse_train(1, 3, 3);
        pulse_train(1, 2, 2);
        check("t3_saw_period6", 32'(saw_p6), 1);
        check("t3_period", 32'(period), 6);
        check("t3_locked", 32'(locked), 0);
        check("t3_fault", 32'(fault_sticky), 1);
        pulse_train(5, 2, 2);
        check("t3_relocked", 32'(locked), 1);
        check("t3_fault_held", 32'(fault_sticky), 1);
        check("t3_period4", 32'(period), 4);

        // 4: clear in the same cycle as a timeout event -> set wins
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("t4_pre_clear", 32'(fault_sticky), 0);
        check("t4_pre_locked", 32'(locked), 1);
        tick(13);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("t4_set_wins", 32'(fault_sticky), 1);
        check("t4_locked", 32'(locked), 0);
        tick(3);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("t4_lone_clear", 32'(fault_sticky), 0);

        // 5: reset while locked, relock needs start edge + 4 good periods
        pulse_train(6, 2, 2);
        check("t5_locked", 32'(locked), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_rst_locked", 32'(locked), 0);
        check("t5_rst_fault", 32'(fault_sticky), 0);
        check("t5_rst_period", 32'(period), 0);
        check("t5_rst_pv", 32'(period_valid), 0);
        pulse_train(4, 2, 2);
        check("t5_not_yet", 32'(locked), 0);
        pulse_train(1, 2, 2);
        check("t5_relocked", 32'(locked), 1);
        check("t5_period", 32'(period), 4);

        // 6: disable for 10 cycles, then re-enable
        enable = 1'b0;
        base = pv_count;
        pulse_train(2, 2, 2);
        tick(2);
        check("t6_locked", 32'(locked), 0);
        check("t6_period_hold", 32'(period), 4);
        check("t6_fault", 32'(fault_sticky), 0);
        check("t6_no_pv", 32'(pv_count - base), 0);
        enable = 1'b1;
        pulse_train(1, 2, 2);
        check("t6_first_rise_silent", 32'(pv_count - base), 0);
        pulse_train(1, 2, 2);
        check("t6_second_rise_pv", 32'(pv_count - base), 1);
        check("t6_period", 32'(period), 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
